// File: rtl/microwave_countdown_timer_if.sv
// Control/time bus between keypad entry logic (master) and the cook-time countdown (slave).
interface microwave_countdown_timer_if;
  logic       load;
  logic [3:0] min_t_in, min_u_in, sec_t_in, sec_u_in;
  logic       start, pause, cancel, door_open;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       heat_on, paused, done, load_err;

  modport master (
    output load, min_t_in, min_u_in, sec_t_in, sec_u_in,
    output start, pause, cancel, door_open,
    input  min_t, min_u, sec_t, sec_u, heat_on, paused, done, load_err
  );

  modport slave (
    input  load, min_t_in, min_u_in, sec_t_in, sec_u_in,
    input  start, pause, cancel, door_open,
    output min_t, min_u, sec_t, sec_u, heat_on, paused, done, load_err
  );
endinterface

// File: rtl/microwave_countdown_timer.sv
// BCD MM:SS cook-time down-counter; stops at 00:00. States: IDLE 00:00 | LOADED nonzero held |
// RUNNING counting, heat on | PAUSED frozen (pause/door) | DONE reached 00:00, waits for cancel/load.
module microwave_countdown_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic                         clk,
  input  logic                         rst_n,
  microwave_countdown_timer_if.slave   bus
);
  localparam int CW = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICKS_PER_SEC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOADED, S_RUNNING, S_PAUSED, S_DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    min_t_q, min_u_q, sec_t_q, sec_u_q;
  logic          heat_on_q, paused_q, done_q, load_err_q;

  logic [3:0]    min_t_d, min_u_d, sec_t_d, sec_u_d;
  logic          dec_zero, load_valid, load_zero;

  // Time minus one second with BCD borrow; only used when the time is nonzero.
  always_comb begin
    min_t_d = min_t_q;
    min_u_d = min_u_q;
    sec_t_d = sec_t_q;
    sec_u_d = sec_u_q - 4'd1;
    if (sec_u_q == 4'd0) begin
      sec_u_d = 4'd9;
      sec_t_d = sec_t_q - 4'd1;
      if (sec_t_q == 4'd0) begin
        sec_t_d = 4'd5;
        min_u_d = min_u_q - 4'd1;
        if (min_u_q == 4'd0) begin
          min_u_d = 4'd9;
          min_t_d = min_t_q - 4'd1;
        end
      end
    end
    dec_zero   = ({min_t_d, min_u_d, sec_t_d, sec_u_d} == 16'd0);
    load_valid = (bus.min_t_in <= 4'd9) && (bus.min_u_in <= 4'd9) &&
                 (bus.sec_t_in <= 4'd5) && (bus.sec_u_in <= 4'd9);
    load_zero  = ({bus.min_t_in, bus.min_u_in, bus.sec_t_in, bus.sec_u_in} == 16'd0);
  end

  always_ff @(posedge clk) begin
    done_q     <= 1'b0;
    load_err_q <= 1'b0;
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      min_t_q   <= 4'd0;
      min_u_q   <= 4'd0;
      sec_t_q   <= 4'd0;
      sec_u_q   <= 4'd0;
      heat_on_q <= 1'b0;
      paused_q  <= 1'b0;
    end else if (bus.cancel) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      min_t_q   <= 4'd0;
      min_u_q   <= 4'd0;
      sec_t_q   <= 4'd0;
      sec_u_q   <= 4'd0;
      heat_on_q <= 1'b0;
      paused_q  <= 1'b0;
    end else if (bus.door_open || bus.pause) begin
      // Freezing cnt here means a pause on the terminal tick retries that second.
      if (state_q == S_RUNNING) begin
        state_q   <= S_PAUSED;
        heat_on_q <= 1'b0;
        paused_q  <= 1'b1;
      end
    end else begin
      case (state_q)
        S_RUNNING: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            min_t_q <= min_t_d;
            min_u_q <= min_u_d;
            sec_t_q <= sec_t_d;
            sec_u_q <= sec_u_d;
            if (dec_zero) begin
              state_q   <= S_DONE;
              heat_on_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PAUSED: begin
          if (bus.start) begin
            state_q   <= S_RUNNING;
            heat_on_q <= 1'b1;
            paused_q  <= 1'b0;
          end
        end
        default: begin
          if (bus.start) begin
            if (state_q == S_LOADED) begin
              state_q   <= S_RUNNING;
              heat_on_q <= 1'b1;
              cnt_q     <= '0;
            end
          end else if (bus.load) begin
            if (!load_valid) begin
              load_err_q <= 1'b1;
            end else begin
              state_q <= load_zero ? S_IDLE : S_LOADED;
              min_t_q <= bus.min_t_in;
              min_u_q <= bus.min_u_in;
              sec_t_q <= bus.sec_t_in;
              sec_u_q <= bus.sec_u_in;
            end
          end
        end
      endcase
    end
  end

  assign bus.min_t    = min_t_q;
  assign bus.min_u    = min_u_q;
  assign bus.sec_t    = sec_t_q;
  assign bus.sec_u    = sec_u_q;
  assign bus.heat_on  = heat_on_q;
  assign bus.paused   = paused_q;
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Directed scenarios plus randomized run checked against a seconds-based reference model.
module tb_microwave_countdown_timer;
  localparam int TPS = 4;
  localparam int MI = 0, ML = 1, MR = 2, MP = 3, MD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  int   m_mode, m_secs, m_sub;
  bit   m_done, m_err;

  microwave_countdown_timer_if bus();

  microwave_countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] obs();
    return {bus.min_t, bus.min_u, bus.sec_t, bus.sec_u,
            bus.heat_on, bus.paused, bus.done, bus.load_err};
  endfunction

  // Expected observation built from remaining seconds and flag values.
  function automatic logic [19:0] pk(int secs, bit h, bit p, bit d, bit e);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), h, p, d, e};
  endfunction

  task automatic idle_inputs();
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.cancel = 1'b0; bus.door_open = 1'b0;
    bus.min_t_in = 4'd0; bus.min_u_in = 4'd0; bus.sec_t_in = 4'd0; bus.sec_u_in = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_time(int mt, int mu, int st, int su);
    bus.load = 1'b1;
    bus.min_t_in = 4'(mt); bus.min_u_in = 4'(mu);
    bus.sec_t_in = 4'(st); bus.sec_u_in = 4'(su);
    tick();
    bus.load = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
  endtask

  task automatic model_step(bit r, bit c, bit dr, bit p, bit s, bit l,
                            int mt, int mu, int st, int su);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!r || c) begin
      m_mode = MI; m_secs = 0; m_sub = 0;
    end else if (dr || p) begin
      if (m_mode == MR) m_mode = MP;
    end else if (m_mode == MR) begin
      if (m_sub == TPS - 1) begin
        m_sub = 0;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = MD; m_done = 1'b1;
        end
      end else begin
        m_sub = m_sub + 1;
      end
    end else if (s) begin
      if (m_mode == ML) begin
        m_mode = MR; m_sub = 0;
      end else if (m_mode == MP) begin
        m_mode = MR;
      end
    end else if (l && m_mode != MP) begin
      if (mt > 9 || mu > 9 || st > 5 || su > 9) begin
        m_err = 1'b1;
      end else begin
        m_secs = (mt * 10 + mu) * 60 + st * 10 + su;
        m_mode = (m_secs == 0) ? MI : ML;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL reset_state: got %h want %h", obs(), 20'h0); end
    rst_n = 1'b1;
    load_time(0, 1, 0, 0);
    pulse_start();
    repeat (10) tick();
    checks++;
    if (obs() !== pk(58, 1, 0, 0, 0)) begin errors++; $display("FAIL run_before_reset: got %h want %h", obs(), pk(58, 1, 0, 0, 0)); end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL reset_mid_run: got %h want %h", obs(), 20'h0); end
    pulse_start();
    tick();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL start_after_reset: got %h want %h", obs(), 20'h0); end
  endtask

  task automatic test_countdown();
    logic [19:0] exp;
    load_time(0, 0, 0, 3);
    checks++;
    if (obs() !== pk(3, 0, 0, 0, 0)) begin errors++; $display("FAIL load_0003: got %h want %h", obs(), pk(3, 0, 0, 0, 0)); end
    pulse_start();
    checks++;
    if (obs() !== pk(3, 1, 0, 0, 0)) begin errors++; $display("FAIL start_0003: got %h want %h", obs(), pk(3, 1, 0, 0, 0)); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (k == 12) ? pk(0, 0, 0, 1, 0) : pk(3 - k / 4, 1, 0, 0, 0);
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL countdown edge %0d: got %h want %h", k, obs(), exp); end
    end
    for (int i = 0; i < 40; i++) begin
      bus.start = (i % 5 == 0);
      bus.pause = (i % 7 == 3);
      tick();
      checks++;
      if (obs() !== 20'h0) begin errors++; $display("FAIL no_wrap cycle %0d: got %h want %h", i, obs(), 20'h0); end
    end
    idle_inputs();
  endtask

  task automatic test_borrow();
    load_time(1, 0, 0, 0);
    pulse_start();
    repeat (TPS) tick();
    checks++;
    if (obs() !== pk(599, 1, 0, 0, 0)) begin errors++; $display("FAIL borrow_1000: got %h want %h", obs(), pk(599, 1, 0, 0, 0)); end
    pulse_cancel();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL cancel_running: got %h want %h", obs(), 20'h0); end
    load_time(0, 0, 1, 0);
    pulse_start();
    repeat (TPS) tick();
    checks++;
    if (obs() !== pk(9, 1, 0, 0, 0)) begin errors++; $display("FAIL borrow_0010: got %h want %h", obs(), pk(9, 1, 0, 0, 0)); end
  endtask

  task automatic test_pause_resume();
    pulse_cancel();
    load_time(0, 0, 0, 5);
    pulse_start();
    repeat (6) tick();
    checks++;
    if (obs() !== pk(4, 1, 0, 0, 0)) begin errors++; $display("FAIL pre_pause: got %h want %h", obs(), pk(4, 1, 0, 0, 0)); end
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== pk(4, 0, 1, 0, 0)) begin errors++; $display("FAIL pause_hold cycle %0d: got %h want %h", i, obs(), pk(4, 0, 1, 0, 0)); end
    end
    bus.pause = 1'b0;
    pulse_start();
    checks++;
    if (obs() !== pk(4, 1, 0, 0, 0)) begin errors++; $display("FAIL resume: got %h want %h", obs(), pk(4, 1, 0, 0, 0)); end
    tick();
    checks++;
    if (obs() !== pk(4, 1, 0, 0, 0)) begin errors++; $display("FAIL resume_wait: got %h want %h", obs(), pk(4, 1, 0, 0, 0)); end
    tick();
    checks++;
    if (obs() !== pk(3, 1, 0, 0, 0)) begin errors++; $display("FAIL resume_dec: got %h want %h", obs(), pk(3, 1, 0, 0, 0)); end
  endtask

  task automatic test_door();
    pulse_cancel();
    load_time(0, 0, 0, 5);
    pulse_start();
    tick();
    bus.door_open = 1'b1;
    tick();
    checks++;
    if (obs() !== pk(5, 0, 1, 0, 0)) begin errors++; $display("FAIL door_pause: got %h want %h", obs(), pk(5, 0, 1, 0, 0)); end
    bus.start = 1'b1;
    tick();
    checks++;
    if (obs() !== pk(5, 0, 1, 0, 0)) begin errors++; $display("FAIL door_start_blocked: got %h want %h", obs(), pk(5, 0, 1, 0, 0)); end
    bus.door_open = 1'b0;
    tick();
    bus.start = 1'b0;
    checks++;
    if (obs() !== pk(5, 1, 0, 0, 0)) begin errors++; $display("FAIL door_closed_start: got %h want %h", obs(), pk(5, 1, 0, 0, 0)); end
  endtask

  task automatic test_invalid_priority();
    pulse_cancel();
    load_time(0, 0, 6, 0);
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 1)) begin errors++; $display("FAIL load_err_0060: got %h want %h", obs(), pk(0, 0, 0, 0, 1)); end
    tick();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL load_err_clear: got %h want %h", obs(), 20'h0); end
    load_time(1, 2, 3, 4);
    checks++;
    if (obs() !== pk(754, 0, 0, 0, 0)) begin errors++; $display("FAIL load_1234: got %h want %h", obs(), pk(754, 0, 0, 0, 0)); end
    load_time(10, 0, 0, 0);
    checks++;
    if (obs() !== pk(754, 0, 0, 0, 1)) begin errors++; $display("FAIL load_err_keep: got %h want %h", obs(), pk(754, 0, 0, 0, 1)); end
    bus.cancel = 1'b1; bus.start = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL cancel_over_start: got %h want %h", obs(), 20'h0); end
    pulse_start();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL start_in_idle: got %h want %h", obs(), 20'h0); end
    load_time(0, 0, 0, 7);
    load_time(0, 0, 0, 0);
    pulse_start();
    checks++;
    if (obs() !== 20'h0) begin errors++; $display("FAIL load_zero_idle: got %h want %h", obs(), 20'h0); end
  endtask

  task automatic test_random();
    bit r, c, dr, p, s, l;
    int mt, mu, st, su;
    logic [19:0] exp;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      c  = ($urandom_range(0, 39) == 0);
      dr = ($urandom_range(0, 11) == 0);
      p  = ($urandom_range(0, 14) == 0);
      s  = ($urandom_range(0, 4) == 0);
      l  = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 3) != 0) begin
        mt = 0; mu = 0; st = $urandom_range(0, 1); su = $urandom_range(0, 9);
      end else begin
        mt = $urandom_range(0, 10); mu = $urandom_range(0, 10);
        st = $urandom_range(0, 6);  su = $urandom_range(0, 10);
      end
      rst_n = r; bus.cancel = c; bus.door_open = dr; bus.pause = p;
      bus.start = s; bus.load = l;
      bus.min_t_in = 4'(mt); bus.min_u_in = 4'(mu);
      bus.sec_t_in = 4'(st); bus.sec_u_in = 4'(su);
      tick();
      model_step(r, c, dr, p, s, l, mt, mu, st, su);
      exp = pk(m_secs, m_mode == MR, m_mode == MP, m_done, m_err);
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL random cycle %0d: got %h want %h", i, obs(), exp); end
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_countdown();
    test_borrow();
    test_pause_resume();
    test_door();
    test_invalid_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microwave_countdown_timer.md
# microwave_countdown_timer

Cook-time countdown for the microwave controller: loads a BCD MM:SS value, then counts it down once per second to 00:00 and stops there without wrapping. It drives the heating enable and a one-cycle completion pulse. It is the down-counting counterpart of the project's 0-to-7 non-recycling up counter and sits between the keypad/entry logic and the magnetron/display logic.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100: clock cycles per timer second. Must be ≥ 2. Benches use 4.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `load`  in  1  capture `min_t_in`, `min_u_in`, `sec_t_in`, `sec_u_in`.
- `min_t_in`, `min_u_in`, `sec_t_in`, `sec_u_in`  in  4 each  BCD time to load.
- `start`  in  1  start or resume counting.
- `pause`  in  1  suspend counting.
- `cancel`  in  1  abort and clear.
- `door_open`  in  1  level input; a high level forces pause.
- `min_t`, `min_u`, `sec_t`, `sec_u`  out  4 each  current remaining time in BCD.
- `heat_on`  out  1  high exactly while the state is RUNNING.
- `paused`  out  1  high while the state is PAUSED.
- `done`  out  1  one-cycle pulse when the count reaches 00:00.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States:
  - IDLE: time = 00:00.
  - LOADED: nonzero time held.
  - RUNNING
  - PAUSED
  - DONE
- Input priority each cycle: `cancel` > `door_open` > `pause` > `start` > `load`. Only the highest-priority active input has effect.
- `cancel`, from any state: go to IDLE and clear the digits to 00:00.
- `load`, in IDLE, LOADED or DONE:
  - Valid ranges: `min_t` 0–9, `min_u` 0–9, `sec_t` 0–5, `sec_u` 0–9.
  - Any digit out of range: digits and state unchanged, `load_err` pulses.
  - Valid and nonzero: capture the digits and go to LOADED.
  - Valid 00:00: go to IDLE.
  - `load` is ignored in RUNNING and PAUSED.
- `start`:
  - LOADED → RUNNING: prescaler cleared to 0.
  - PAUSED → RUNNING: prescaler keeps its value.
  - Ignored when `door_open` = 1, and ignored in IDLE, DONE and RUNNING.
- `pause` or `door_open` in RUNNING → PAUSED. The prescaler freezes.
- Prescaler `cnt` (width clog2(`TICKS_PER_SEC`)):
  - In RUNNING it increments every cycle.
  - At `TICKS_PER_SEC`-1 it returns to 0 and the time decrements by one second.
- Decrement uses BCD borrow:
  - `sec_u` 0 → 9 and borrow from `sec_t`.
  - `sec_t` 0 → 5 and borrow from `min_u`.
  - `min_u` 0 → 9 and borrow from `min_t`.
- If a decrement produces 00:00: go to DONE and pulse `done`.
- Non-recycling: 00:00 is never decremented. 99:59 can only be reached by loading it.
- DONE holds 00:00 until `cancel` or `load`. `start` and `pause` are ignored.

## Timing
- All outputs are registered. Each change is visible after the clock edge that causes it.
- Reset values: state IDLE, digits 0, `cnt` 0, `heat_on`/`paused`/`done`/`load_err` = 0.
- Reset takes effect on any edge with `rst_n` = 0, including mid-RUNNING. It overrides every other input.
- `heat_on` rises on the edge that enters RUNNING and falls on the edge that leaves it. There is no extra latency.
- From LOADED, the first decrement occurs on the `TICKS_PER_SEC`-th edge after the edge that entered RUNNING.
- An S-second load reaches DONE after S × `TICKS_PER_SEC` RUNNING cycles.
- `done` is high for exactly the first cycle of DONE, together with `heat_on` = 0 and digits 00:00.
- `load_err` is high for exactly the one cycle after the rejecting edge.
- Simultaneous terminal tick and `pause`/`door_open`: the pause wins and no decrement occurs. That second is retried with `cnt` frozen at `TICKS_PER_SEC`-1.

## Test plan
With `TICKS_PER_SEC` = 4:
- Reset mid-run: load 01:00, start, run 10 cycles, hold `rst_n` = 0 for 1 edge → digits 00:00, all outputs 0, state IDLE; then `start` alone → `heat_on` stays 0.
- Basic countdown: load 00:03, start → `sec_u` reads 2, 1, 0 after RUNNING edges 4, 8, 12. `done` = 1 only in the cycle after edge 12, `heat_on` = 0 from then on, and digits stay 00:00 for the next 40 cycles (no wrap).
- Borrow chain: load 10:00, start, 4 cycles → 09:59. Load 00:10, run 1 second → 00:09.
- Pause/resume: load 00:05, start, 6 cycles (reads 00:04, `cnt` = 2), pause for 10 cycles → `paused` = 1, digits frozen. Start → 00:03 appears after 2 cycles.
- Door interlock: running 00:05, `door_open` = 1 → PAUSED next edge; start with the door open → still PAUSED; door closed plus start → RUNNING.
- Invalid load and priority: load 00:60 → `load_err` pulses and digits are unchanged. `cancel` and `start` asserted together in LOADED → IDLE, 00:00, `heat_on` = 0.
